// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit instruction words and
// writes them into instruction memory. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        WE,
    output logic [31:0] WA,
    output logic [31:0] WD,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTE,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_FIN
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] idx, last_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;
    logic [8:0]       n_eff;
    logic             over;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xsum;
`endif

    // A count byte of zero stands for a full memory image.
    assign n_eff = (rx_data == 8'd0) ? 9'(DEPTH) : {1'b0, rx_data};
    assign over  = n_eff > 9'(DEPTH);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_next = state;
        rx_ready   = 1'b0;
        WE         = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_COUNT;
            end
            S_COUNT: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = over ? S_FIN : S_BYTE;
            end
            S_BYTE: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                WE = 1'b1;
                if (idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_FIN;
`endif
                end else begin
                    state_next = S_BYTE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_FIN;
            end
`endif
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the pre-edge values.
        if (!reset_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            last_idx <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            WA       <= '0;
            WD       <= '0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        idx      <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (rx_valid) begin
                        last_idx <= CNT_W'(n_eff - 9'd1);
                        if (over) err <= 1'b1;
                    end
                end
                S_BYTE: begin
                    if (rx_valid) begin
                        asm_q    <= {asm_q[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ rx_data;
`endif
                        // WA/WD are loaded once per word and then held until the next word.
                        if (byte_cnt == 2'd3) begin
                            WA <= 32'(idx);
                            WD <= {asm_q, rx_data};
                        end
                    end
                end
                S_WRITE: idx <= idx + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid && rx_data != xsum) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are decoded by a format-level model
// into expected writes and error status, then compared against the captured writes.
module tb_imem_loader;
    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic        clk = 1'b0;
    logic        reset_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, WE, busy, done, err;
    logic [31:0] WA, WD;

    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    logic [31:0] wr_a[$], wr_d[$], exp_a[$], exp_d[$];
    logic [7:0]  stream[$];
    logic        exp_err;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .WE(WE), .WA(WA), .WD(WD),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (WE === 1'b1) begin
            wr_a.push_back(WA);
            wr_d.push_back(WD);
            check("ready_in_write", 32'(rx_ready), 32'd0);
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("busy_with_done", 32'(busy), 32'd1);
        end
    end

    // Decode the stream by its format rules into the writes and error it must produce.
    task automatic model();
        int         n;
        logic [7:0] x;
        exp_a.delete();
        exp_d.delete();
        x = 8'h00;
        n = (stream[0] == 8'h00) ? DEPTH : int'(stream[0]);
        exp_err = (n > DEPTH);
        if (exp_err) return;
        for (int w = 0; w < n; w++) begin
            exp_a.push_back(32'(w));
            exp_d.push_back({stream[1+4*w], stream[2+4*w], stream[3+4*w], stream[4+4*w]});
            for (int k = 1; k <= 4; k++) x ^= stream[4*w+k];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = (stream[1+4*n] != x);
`endif
    endtask

    task automatic add_ck(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < stream.size(); i++) x ^= stream[i];
        stream.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
`else
        if (good) return;
`endif
    endtask

    task automatic rand_stream(input int cnt, input bit good);
        int n;
        stream = {8'(cnt)};
        n = (cnt == 0) ? DEPTH : cnt;
        if (n > DEPTH) return;
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
        add_ck(good);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int guard;
        guard = 0;
        if (gaps) begin
            // start pulses during gaps must be ignored while a load is in progress
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                start    = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 40) begin
                check("accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_we"}, 32'(WE), 32'd0);
        check({tag, "_wa"}, WA, 32'd0);
        check({tag, "_wd"}, WD, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic run(input string tag, input bit gaps);
        int d0;
        int guard;
        model();
        wr_a.delete();
        wr_d.delete();
        d0    = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        foreach (stream[i]) send_byte(stream[i], gaps);
        guard = 0;
        while (done_cnt == d0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_nwrites"}, 32'(wr_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < wr_a.size()) begin
                check({tag, "_wa"}, wr_a[i], exp_a[i]);
                check({tag, "_wd"}, wr_d[i], exp_d[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        stream = {8'h01, 8'h02, 8'h32, 8'h80, 8'h20};
        add_ck(1'b1);
        run("single", 1'b0);
        check("single_wd_const", (wr_d.size() > 0) ? wr_d[0] : 32'hxxxxxxxx, 32'h02328020);

        rand_stream(0, 1'b1);
        run("full", 1'b0);

        rand_stream(33, 1'b1);
        run("overflow", 1'b0);
        rand_stream(DEPTH + 1 + $urandom_range(0, 200), 1'b1);
        run("overflow_rand", 1'b0);

        stream = {8'h01, 8'h02, 8'h32, 8'h80, 8'h20};
        add_ck(1'b1);
        run("clear_err", 1'b0);

        rand_stream(2, 1'b1);
        run("two_nogap", 1'b0);
        run("two_gap", 1'b1);

        for (int t = 0; t < 6; t++) begin
            rand_stream($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)));
            run("rand", 1'($urandom_range(0, 1)));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        stream = {8'h01, 8'h02, 8'h32, 8'h80, 8'h20};
        add_ck(1'b0);
        run("ck_bad", 1'b0);
`endif

        // Reset after two full words and half of the third.
        rand_stream(3, 1'b1);
        wr_a.delete();
        wr_d.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(stream[i], 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_idle("midreset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_writes", 32'(wr_a.size()), 32'd2);

        rand_stream(2, 1'b1);
        run("after_reset", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
